// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART transmit arbiter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam int   DATA_BITS  = 8;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam int   FRAME_BITS = 10;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches last+1, last+2, ... modulo NUM_REQ
// and grants the first active requester.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx,
  output logic               any_req
);

  logic [IW-1:0] cand;

  // Rotating priority search starting just after the previous winner.
  always_comb begin
    grant   = '0;
    idx     = '0;
    any_req = 1'b0;
    cand    = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = IW'((32'(last) + off) % NUM_REQ);
      if (!any_req && req[cand]) begin
        any_req     = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one 8N1 transmit line between NUM_REQ byte producers, one byte per
// round-robin grant, with an internal baud divider.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 16,
  localparam int IW = $clog2(NUM_REQ),
  localparam int CW = $clog2(CLKS_PER_BIT)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx,
  output logic                 busy,
  output logic [IW-1:0]        grant_id
);

  state_t        state, state_nx;
  logic [CW-1:0] baud, baud_nx;
  logic [2:0]    bit_idx, bit_nx;
  logic [7:0]    shift, shift_nx;
  logic [IW-1:0] last, last_nx;
  logic [IW-1:0] grant_nx;
  logic          tx_nx, busy_nx;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IW-1:0]      arb_idx;
  logic               arb_any;
  logic [7:0]         win_data;
  logic               baud_tc;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (req_valid),
    .last    (last),
    .grant   (arb_grant),
    .idx     (arb_idx),
    .any_req (arb_any)
  );

  assign baud_tc = (baud == CW'(CLKS_PER_BIT - 1));

  // Select the winning requester's byte from the one-hot grant.
  always_comb begin
    win_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) win_data = req_data[8*i +: 8];
    end
  end

  // Next-state, datapath and output logic; tx/busy are computed one cycle
  // ahead so the registered line changes exactly on state transitions.
  always_comb begin
    state_nx  = state;
    baud_nx   = baud + CW'(1);
    bit_nx    = bit_idx;
    shift_nx  = shift;
    last_nx   = last;
    grant_nx  = grant_id;
    tx_nx     = tx;
    busy_nx   = busy;
    req_ready = '0;
    case (state)
      IDLE: begin
        baud_nx = '0;
        tx_nx   = STOP_BIT;
        busy_nx = 1'b0;
        if (arb_any) begin
          req_ready = arb_grant;
          shift_nx  = win_data;
          grant_nx  = arb_idx;
          last_nx   = arb_idx;
          state_nx  = START;
          tx_nx     = START_BIT;
          busy_nx   = 1'b1;
        end
      end
      START: begin
        if (baud_tc) begin
          baud_nx  = '0;
          bit_nx   = '0;
          state_nx = DATA;
          tx_nx    = shift[0];
        end
      end
      DATA: begin
        if (baud_tc) begin
          baud_nx = '0;
          if (bit_idx == 3'(DATA_BITS - 1)) begin
            bit_nx   = '0;
            state_nx = STOP;
            tx_nx    = STOP_BIT;
          end else begin
            shift_nx = shift >> 1;
            bit_nx   = bit_idx + 3'd1;
            tx_nx    = shift[1];
          end
        end
      end
      STOP: begin
        if (baud_tc) begin
          baud_nx  = '0;
          state_nx = IDLE;
          tx_nx    = STOP_BIT;
          busy_nx  = 1'b0;
        end
      end
      default: begin
        state_nx = IDLE;
        baud_nx  = '0;
      end
    endcase
    // State already reads IDLE while reset is held; keep ready quiet then.
    if (!reset) req_ready = '0;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      baud     <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      last     <= IW'(NUM_REQ - 1);
      grant_id <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      baud     <= baud_nx;
      bit_idx  <= bit_nx;
      shift    <= shift_nx;
      last     <= last_nx;
      grant_id <= grant_nx;
      tx       <= tx_nx;
      busy     <= busy_nx;
    end
  end

endmodule
